// File: rtl/mem_avalon_master_if.sv
// Avalon-MM bus bundle between the MEM-stage master and a data memory slave.
interface mem_avalon_master_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        output avm_write,
        output avm_writedata,
        output avm_byteenable,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        input  avm_write,
        input  avm_writedata,
        input  avm_byteenable,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );
endinterface

// File: rtl/mem_avalon_master.sv
// MEM-stage data access unit: turns EX/MEM load/store requests into
// Avalon-MM transfers, stalls the pipeline and extends load data.
module mem_avalon_master #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic [2:0]  Funct3,
    output logic        oStall,
    output logic [31:0] oRData,
    output logic        oRDataValid,
    output logic        oMisaligned,
    output logic        oTimeout,
    mem_avalon_master_if.master avm
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_REQ  = 3'd1;
    localparam logic [2:0] RD_REQ  = 3'd2;
    localparam logic [2:0] RD_WAIT = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]    state;
    logic [1:0]    lat_a;
    logic [2:0]    lat_f3;
    logic [CW-1:0] cnt;
    logic          expired;
    logic          req;
    logic          illegal;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic [31:0]   ext;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;

    assign req     = MemRead | MemWrite;
    assign expired = (cnt == CNT_LAST);

    assign oStall = ((state == IDLE) & req)
                  | (state == WR_REQ)
                  | (state == RD_REQ)
                  | (state == RD_WAIT);

    always_comb begin
        illegal = (Funct3 == 3'b011)
                | (Funct3[2:1] == 2'b11)
                | (MemWrite & Funct3[2])
                | ((Funct3[1:0] == 2'b01) & Addr[0])
                | ((Funct3[1:0] == 2'b10) & (Addr[1:0] != 2'b00));
    end

    always_comb begin
        be = 4'b1111;
        wd = WData;
        case (Funct3[1:0])
            2'b00: begin
                be = 4'b0001 << Addr[1:0];
                wd = {4{WData[7:0]}};
            end
            2'b01: begin
                be = 4'b0011 << {Addr[1], 1'b0};
                wd = {2{WData[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = WData;
            end
        endcase
    end

    // Lane select uses the latched address; the bus returns a whole word.
    always_comb begin
        rbyte = avm.avm_readdata[{lat_a, 3'b000} +: 8];
        rhalf = lat_a[1] ? avm.avm_readdata[31:16]
                         : avm.avm_readdata[15:0];
        case (lat_f3)
            3'b000:  ext = {{24{rbyte[7]}}, rbyte};
            3'b100:  ext = {24'd0, rbyte};
            3'b001:  ext = {{16{rhalf[15]}}, rhalf};
            3'b101:  ext = {16'd0, rhalf};
            default: ext = avm.avm_readdata;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state              <= IDLE;
            lat_a              <= 2'd0;
            lat_f3             <= 3'd0;
            cnt                <= '0;
            oRData             <= 32'd0;
            oRDataValid        <= 1'b0;
            oMisaligned        <= 1'b0;
            oTimeout           <= 1'b0;
            avm.avm_address    <= '0;
            avm.avm_read       <= 1'b0;
            avm.avm_write      <= 1'b0;
            avm.avm_writedata  <= 32'd0;
            avm.avm_byteenable <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_a  <= Addr[1:0];
                        lat_f3 <= Funct3;
                        cnt    <= '0;
                        if (illegal) begin
                            oMisaligned <= 1'b1;
                            state       <= DONE;
                        end else begin
                            avm.avm_address    <= ADDR_W'({Addr[31:2], 2'b00});
                            avm.avm_byteenable <= be;
                            avm.avm_writedata  <= wd;
                            if (MemWrite) begin
                                avm.avm_write <= 1'b1;
                                state         <= WR_REQ;
                            end else begin
                                avm.avm_read <= 1'b1;
                                state        <= RD_REQ;
                            end
                        end
                    end
                end
                WR_REQ: begin
                    cnt <= cnt + 1'b1;
                    if (!avm.avm_waitrequest) begin
                        avm.avm_write <= 1'b0;
                        state         <= DONE;
                    end else if (expired) begin
                        avm.avm_write <= 1'b0;
                        oTimeout      <= 1'b1;
                        state         <= DONE;
                    end
                end
                RD_REQ: begin
                    cnt <= cnt + 1'b1;
                    if (!avm.avm_waitrequest) begin
                        avm.avm_read <= 1'b0;
                        if (avm.avm_readdatavalid) begin
                            oRData      <= ext;
                            oRDataValid <= 1'b1;
                            state       <= DONE;
                        end else if (expired) begin
                            oRData      <= 32'd0;
                            oRDataValid <= 1'b1;
                            oTimeout    <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end else if (expired) begin
                        avm.avm_read <= 1'b0;
                        oRData       <= 32'd0;
                        oRDataValid  <= 1'b1;
                        oTimeout     <= 1'b1;
                        state        <= DONE;
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (avm.avm_readdatavalid) begin
                        oRData      <= ext;
                        oRDataValid <= 1'b1;
                        state       <= DONE;
                    end else if (expired) begin
                        oRData      <= 32'd0;
                        oRDataValid <= 1'b1;
                        oTimeout    <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    oRDataValid <= 1'b0;
                    oMisaligned <= 1'b0;
                    oTimeout    <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_avalon_master.sv
// Bench for mem_avalon_master: vector table plus bus-slave model and
// scoreboards for bus transfers and load results.
module tb_mem_avalon_master;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        o_stall;
    logic [31:0] o_rdata;
    logic        o_rdv;
    logic        o_mis;
    logic        o_to;

    int total = 0;
    int bad   = 0;

    mem_avalon_master_if #(.ADDR_W(32)) bus ();

    mem_avalon_master #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .CLK(clk),
        .RST(rst),
        .MemRead(mem_read),
        .MemWrite(mem_write),
        .Addr(addr),
        .WData(wdata),
        .Funct3(f3),
        .oStall(o_stall),
        .oRData(o_rdata),
        .oRDataValid(o_rdv),
        .oMisaligned(o_mis),
        .oTimeout(o_to),
        .avm(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [2:0]  f3;
        int          wait_n;
        int          rdv_n;
        logic [31:0] rdat;
        logic [31:0] e_a;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        int          e_stall;
        int          e_hi;
        int          e_pv;
        logic        e_mis;
        logic        e_to;
        logic        e_acc;
    } vec_t;

    bus_t        bus_q[$];
    logic [31:0] rd_q[$];

    int          cfg_wait  = 0;
    int          cfg_rdv   = -1;
    logic [31:0] cfg_rdata = 32'd0;
    int          wcnt      = 0;
    int          rcnt      = 0;
    bit          pend      = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic bus_accept(input logic wr);
        bus_t e;
        if (bus_q.size() == 0) begin
            chk("bus_unexpected", 32'd1, 32'd0);
        end else begin
            e = bus_q.pop_front();
            chk("bus_dir", 32'(wr), 32'(e.wr));
            chk("bus_addr", bus.avm_address, e.a);
            chk("bus_be", 32'(bus.avm_byteenable), 32'(e.be));
            if (wr) chk("bus_wdata", bus.avm_writedata, e.wd);
        end
    endtask

    // Slave model: waitrequest for cfg_wait cycles, then read data
    // cfg_rdv cycles after the accept (negative = never).
    always @(negedge clk) begin
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = 32'h5A5A_5A5A;
        if (pend) begin
            if (rcnt == 0) begin
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = cfg_rdata;
                pend = 0;
            end else begin
                rcnt--;
            end
        end
        bus.avm_waitrequest = 1'b0;
        if (bus.avm_read || bus.avm_write) begin
            if (wcnt < cfg_wait) begin
                bus.avm_waitrequest = 1'b1;
                wcnt++;
            end else begin
                wcnt = 0;
                bus_accept(bus.avm_write);
                if (bus.avm_read) begin
                    if (cfg_rdv == 0) begin
                        bus.avm_readdatavalid = 1'b1;
                        bus.avm_readdata      = cfg_rdata;
                    end else if (cfg_rdv > 0) begin
                        pend = 1;
                        rcnt = cfg_rdv - 1;
                    end
                end
            end
        end else begin
            wcnt = 0;
        end
    end

    function automatic vec_t mk(
        logic rd, logic wr, logic [31:0] a, logic [31:0] wd,
        logic [2:0] fn, int wn, int rn, logic [31:0] rdat,
        logic [31:0] ea, logic [3:0] ebe, logic [31:0] ewd,
        logic [31:0] erd, int est, int ehi, int epv,
        logic emis, logic eto, logic eacc);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.f3 = fn;
        v.wait_n = wn; v.rdv_n = rn; v.rdat = rdat;
        v.e_a = ea; v.e_be = ebe; v.e_wd = ewd; v.e_rd = erd;
        v.e_stall = est; v.e_hi = ehi; v.e_pv = epv;
        v.e_mis = emis; v.e_to = eto; v.e_acc = eacc;
        return v;
    endfunction

    task automatic run(input vec_t v);
        int   st  = 0;
        int   hi  = 0;
        int   pv  = 0;
        logic m   = 1'b0;
        logic t   = 1'b0;
        bit   fin = 0;
        cfg_wait  = v.wait_n;
        cfg_rdv   = v.rdv_n;
        cfg_rdata = v.rdat;
        if (v.e_acc) bus_q.push_back('{v.wr, v.e_a, v.e_be, v.e_wd});
        if (v.e_pv == 1) rd_q.push_back(v.e_rd);
        mem_read  = v.rd;
        mem_write = v.wr;
        addr      = v.a;
        wdata     = v.wd;
        f3        = v.f3;
        for (int c = 0; c < 100 && !fin; c++) begin
            @(negedge clk);
            if (c == 0)
                chk("pulse_clear", 32'({o_rdv, o_mis, o_to}), 32'd0);
            hi += int'(bus.avm_write) + int'(bus.avm_read);
            if (o_rdv) begin
                pv++;
                if (rd_q.size() != 0)
                    chk("rdata", o_rdata, rd_q.pop_front());
                else if (v.e_pv == 0)
                    chk("rdv_unexpected", 32'd1, 32'd0);
            end
            if (o_stall) begin
                st++;
            end else begin
                fin = 1;
                m   = o_mis;
                t   = o_to;
            end
        end
        if (!fin) chk("done_reached", 32'd0, 32'd1);
        chk("stall_cycles", st, v.e_stall);
        chk("misaligned", 32'(m), 32'(v.e_mis));
        chk("timeout", 32'(t), 32'(v.e_to));
        chk("bus_cycles", hi, v.e_hi);
        if (v.e_pv >= 0) chk("rdv_pulses", pv, v.e_pv);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        vec_t vecs[$];
        int   hits;

        vecs.push_back(mk(0, 1, 32'h104, 32'hDEADBEEF, 3'b010, 2, -1, 0,
            32'h104, 4'hF, 32'hDEADBEEF, 0, 4, 3, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h203, 32'h000000A5, 3'b000, 0, -1, 0,
            32'h200, 4'h8, 32'hA5A5A5A5, 0, 2, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h102, 32'h1234ABCD, 3'b001, 1, -1, 0,
            32'h100, 4'hC, 32'hABCDABCD, 0, 3, 2, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 32'h108, 0, 3'b010, 0, 1, 32'hCAFEF00D,
            32'h108, 4'hF, 0, 32'hCAFEF00D, 3, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 32'h101, 0, 3'b000, 0, 2, 32'h0000F200,
            32'h100, 4'h2, 0, 32'hFFFFFFF2, 4, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 32'h102, 0, 3'b101, 0, 1, 32'h80011234,
            32'h100, 4'hC, 0, 32'h00008001, 3, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 32'h100, 0, 3'b001, 1, 0, 32'h00008001,
            32'h100, 4'h3, 0, 32'hFFFF8001, 3, 2, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 32'h103, 0, 3'b100, 0, 1, 32'h9A000000,
            32'h100, 4'h8, 0, 32'h0000009A, 3, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 32'h102, 0, 3'b000, 0, 1, 32'h007F0000,
            32'h100, 4'h4, 0, 32'h0000007F, 3, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 32'h102, 0, 3'b010, 0, 1, 0,
            0, 0, 0, 0, 1, 0, -1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 32'h100, 0, 3'b011, 0, 1, 0,
            0, 0, 0, 0, 1, 0, -1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h100, 32'h55, 3'b100, 0, -1, 0,
            0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 32'h100, 0, 3'b110, 0, 1, 0,
            0, 0, 0, 0, 1, 0, -1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h101, 32'h77, 3'b001, 0, -1, 0,
            0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 32'h010, 32'h11223344, 3'b010, 0, -1, 0,
            32'h010, 4'hF, 32'h11223344, 0, 2, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 32'h10C, 0, 3'b010, 0, -1, 32'h12345678,
            32'h10C, 4'hF, 0, 32'h0, 9, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 32'h020, 32'h0BADF00D, 3'b010, 100, -1, 0,
            32'h020, 4'hF, 32'h0BADF00D, 0, 9, 8, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 32'h102, 0, 3'b001, 3, 3, 32'hF00D1234,
            32'h100, 4'hC, 0, 32'hFFFFF00D, 8, 4, 1, 0, 0, 1));

        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 32'd0;
        wdata     = 32'd0;
        f3        = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_pulses", 32'({o_rdv, o_mis, o_to}), 32'd0);
        chk("rst_rw", 32'({bus.avm_read, bus.avm_write}), 32'd0);
        chk("rst_addr", bus.avm_address, 32'd0);
        chk("rst_be_wd", 32'(bus.avm_byteenable) | bus.avm_writedata,
            32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) run(vecs[i]);

        // Reset lands while the read is waiting for data; the late
        // readdatavalid must be ignored.
        cfg_wait  = 0;
        cfg_rdv   = 3;
        cfg_rdata = 32'h87654321;
        bus_q.push_back('{1'b0, 32'h200, 4'hF, 32'd0});
        mem_read = 1'b1;
        addr     = 32'h200;
        f3       = 3'b010;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_rdv || o_stall || bus.avm_read || bus.avm_write ||
                o_rdata != 32'd0)
                hits++;
        end
        chk("reset_mid_read", hits, 0);

        chk("bus_q_empty", bus_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_avalon_master.md
Name: mem_avalon_master

Overview:
MEM-stage data-memory access unit of the pipelined RISC-V core. It consumes the EX/MEM pipeline register outputs (MemRead, MemWrite, ALU result as address, Reg2 as store data) and performs the access as an Avalon-MM master. It stalls the pipeline through the register Enable inputs and returns sign- or zero-extended load data to the MEM/WB path. Misaligned accesses, illegal sizes and bus timeouts are flagged.

Parameters:
ADDR_W, 32, width of avm_address (byte address, word-aligned on the bus)
TIMEOUT, 255, max cycles spent in any bus-wait state before abort (≥2)

Ports:
CLK  in  1  clock, all logic on posedge
RST  in  1  reset, synchronous, active-high
MemRead  in  1  load request from EX/MEM register
MemWrite  in  1  store request from EX/MEM register
Addr  in  32  byte address (ALU result)
WData  in  32  store data (Reg2)
Funct3  in  3  access size/sign (RV32I load/store funct3)
oStall  out  1  high = hold pipeline (drives Enable low on pipeline registers)
oRData  out  32  extended load data
oRDataValid  out  1  one-cycle pulse, oRData updated
oMisaligned  out  1  one-cycle pulse, access rejected
oTimeout  out  1  one-cycle pulse, bus access aborted
avm_address  out  ADDR_W  word address (Addr[1:0] forced 0)
avm_read  out  1  Avalon read
avm_write  out  1  Avalon write
avm_writedata  out  32  lane-replicated store data
avm_byteenable  out  4  byte lanes
avm_waitrequest  in  1  slave stall
avm_readdata  in  32  read data
avm_readdatavalid  in  1  read data strobe

Behaviour:
- Reset (RST high at posedge): state IDLE; all outputs 0 (oRData=0, avm_* =0, pulses 0); timeout counter 0. Applies mid-transaction: avm_read/avm_write drop at that edge; late avm_readdatavalid after reset is ignored.
- States: IDLE, WR_REQ, RD_REQ, RD_WAIT, DONE. Avalon outputs are registered.
- oStall = (IDLE & (MemRead|MemWrite)) | WR_REQ | RD_REQ | RD_WAIT. Low in DONE, so the pipeline advances exactly once per access.
- IDLE: request present -> latch Addr/WData/Funct3, check legality:
  - illegal: Funct3 ∈ {011,110,111}; Funct3=100/101 on a store; halfword with Addr[0]=1; word with Addr[1:0]≠0. Goes to DONE with oMisaligned=1 in DONE. No bus cycle.
  - MemWrite (wins if both asserted) -> WR_REQ; MemRead -> RD_REQ.
- Byteenable: byte 4'b0001<<Addr[1:0]; half 4'b0011<<{Addr[1],1'b0}; word 4'b1111. writedata: byte {4{WData[7:0]}}, half {2{WData[15:0]}}, word WData.
- WR_REQ: avm_write=1 while avm_waitrequest=1; on waitrequest=0 -> DONE, avm_write=0 next cycle.
- RD_REQ: avm_read=1 until waitrequest=0. If readdatavalid in the accept cycle -> DONE, else RD_WAIT. readdatavalid is sampled only in RD_REQ (accept cycle) and RD_WAIT.
- RD_WAIT: on readdatavalid, capture lane, extend, -> DONE.
- Load extend: LB/LBU byte Addr[1:0]; LH/LHU half Addr[1]; sign-extend for 000/001, zero-extend for 100/101, LW raw.
- DONE: oRDataValid=1 for loads (oRData valid this cycle, held until next load). Inputs ignored (EX/MEM still holds the finished instruction). -> IDLE.
- Minimum latency, zero waitrequest: store 2 stall cycles + DONE; load with readdatavalid one cycle after accept: 3 stall cycles + DONE.
- Timeout: counter clears on entering WR_REQ/RD_REQ and increments each cycle in WR_REQ/RD_REQ/RD_WAIT. At TIMEOUT it deasserts avm_read/avm_write and goes to DONE with oTimeout=1. oRData is forced 0 and oRDataValid=1 for a load. This is a deliberate bus-error recovery.
- No request in IDLE: oStall=0, bus idle.

Test Plan:
- SW Addr=0x104, WData=0xDEADBEEF, waitrequest high 2 cycles -> avm_address=0x104, be=1111, avm_write held 3 cycles, oStall low only in DONE, no second write.
- SB Addr=0x203, WData=0x000000A5 -> be=1000, writedata=0xA5A5A5A5.
- LB Addr=0x101, readdata=0x0000F200 after 2 cycles -> oRData=0xFFFFFFF2, oRDataValid 1 cycle. LHU Addr=0x102, readdata=0x8001xxxx -> oRData=0x00008001.
- LW Addr=0x102 -> no avm_read, oMisaligned pulse, 1 stall cycle; Funct3=011 load -> same.
- Load with readdatavalid never asserted, TIMEOUT=8 -> avm_read drops, oTimeout and oRDataValid pulse, oRData=0.
- RST high in RD_WAIT, then readdatavalid -> all outputs 0, IDLE, no oRDataValid. Back-to-back SW then LW -> exactly one write and one read, in order.
